prog_loader: RTL

//  Writer side of the program-memory interface the CPU reads. Receives a byte stream
//  (valid/ready, e.g. from a UART receiver), assembles 16-bit instruction words and writes

---
 rtl/prog_loader_if.sv | 16 +
 rtl/prog_loader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream and program-memory write bus for prog_loader.
// slave = the loader (consumes bytes, drives memory writes); master = its environment.
interface prog_loader_if #(
  parameter int ADDR_LENGTH = 11,
  parameter int DATA_LENGTH = 16
);
  logic [7:0]             i_byte;
  logic                   i_valid;
  logic                   o_ready;
  logic [ADDR_LENGTH-1:0] o_Addr;
  logic [DATA_LENGTH-1:0] o_Data;
  logic                   o_Wr;

  modport master (output i_byte, i_valid, input o_ready, o_Addr, o_Data, o_Wr);
  modport slave  (input i_byte, i_valid, output o_ready, o_Addr, o_Data, o_Wr);
endinterface

// File: rtl/prog_loader.sv
// Assembles a length-prefixed byte stream into 16-bit words and writes them to program memory,
// holding the CPU in reset until the load completes. Optional trailing XOR checksum: PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int MEM_SIZE    = 9,
  parameter int ADDR_LENGTH = 11,
  parameter int DATA_LENGTH = 16
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_reload,
  prog_loader_if.slave  bus,
  output logic          o_cpu_rst,
  output logic          o_done,
  output logic          o_error
);

  // One extra bit so the word count can represent a full memory (2**MEM_SIZE words).
  localparam int CW = MEM_SIZE + 1;

  typedef enum logic [2:0] {
    S_LEN_H, S_LEN_L, S_DAT_H, S_DAT_L, S_WRITE, S_DONE, S_ERR
`ifdef PROG_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t                 r_state;
  logic [7:0]             r_hi;
  logic [CW-1:0]          r_len;
  logic [CW-1:0]          r_count;
  logic                   r_ready;
  logic                   r_wr;
  logic [ADDR_LENGTH-1:0] r_addr;
  logic [DATA_LENGTH-1:0] r_data;
  logic                   r_cpuRst;
  logic                   r_done;
  logic                   r_error;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]             r_sum;
`endif

  logic          w_accept;
  logic [15:0]   w_len;
  logic          w_tooBig;
  logic [CW-1:0] w_countNext;

  assign w_accept    = bus.i_valid && r_ready;
  assign w_len       = {r_hi, bus.i_byte};
  assign w_tooBig    = {16'd0, w_len} > (32'd1 << MEM_SIZE);
  assign w_countNext = r_count + 1'b1;

  assign bus.o_ready = r_ready;
  assign bus.o_Addr  = r_addr;
  assign bus.o_Data  = r_data;
  assign bus.o_Wr    = r_wr;
  assign o_cpu_rst   = r_cpuRst;
  assign o_done      = r_done;
  assign o_error     = r_error;

  // r_ready always mirrors whether the state being entered consumes bytes.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= S_LEN_H;
      r_hi     <= '0;
      r_len    <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_cpuRst <= 1'b1;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_sum    <= '0;
`endif
    end else begin
      r_wr <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      if (w_accept && r_state != S_CHK) r_sum <= r_sum ^ bus.i_byte;
`endif
      case (r_state)
        S_LEN_H: begin
          if (w_accept) begin
            r_hi    <= bus.i_byte;
            r_state <= S_LEN_L;
          end
        end
        S_LEN_L: begin
          if (w_accept) begin
            r_count <= '0;
            if (w_tooBig) begin
              r_state <= S_ERR;
              r_ready <= 1'b0;
              r_error <= 1'b1;
            end else begin
              r_len <= w_len[CW-1:0];
              if (w_len == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                r_state  <= S_CHK;
`else
                r_state  <= S_DONE;
                r_ready  <= 1'b0;
                r_done   <= 1'b1;
                r_cpuRst <= 1'b0;
`endif
              end else begin
                r_state <= S_DAT_H;
              end
            end
          end
        end
        S_DAT_H: begin
          if (w_accept) begin
            r_hi    <= bus.i_byte;
            r_state <= S_DAT_L;
          end
        end
        S_DAT_L: begin
          if (w_accept) begin
            r_data  <= DATA_LENGTH'({r_hi, bus.i_byte});
            r_addr  <= ADDR_LENGTH'(r_count[MEM_SIZE-1:0]);
            r_wr    <= 1'b1;
            r_ready <= 1'b0;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_count <= w_countNext;
          if (w_countNext == r_len) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            r_state  <= S_CHK;
            r_ready  <= 1'b1;
`else
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_cpuRst <= 1'b0;
`endif
          end else begin
            r_state <= S_DAT_H;
            r_ready <= 1'b1;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            if (bus.i_byte == r_sum) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_cpuRst <= 1'b0;
            end else begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end
          end
        end
`endif
        S_DONE, S_ERR: begin
          if (i_reload) begin
            r_state  <= S_LEN_H;
            r_ready  <= 1'b1;
            r_cpuRst <= 1'b1;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_count  <= '0;
            r_len    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum    <= '0;
`endif
          end
        end
        default: begin
          r_state <= S_ERR;
          r_ready <= 1'b0;
          r_error <= 1'b1;
        end
      endcase
    end
  end

endmodule
